// File: rtl/scan_selector.sv
// scan_selector: N-channel, W-bit registered selector.
// Manual mode forwards the channel chosen by sel. Auto-scan mode steps
// round-robin through all channels, showing each for DWELL edges, and
// pulses wrap on the edge where the scan returns from CH-1 to 0.
module scan_selector #(
  parameter int CH    = 4,
  parameter int W     = 2,
  parameter int SELW  = (CH > 1) ? $clog2(CH) : 1,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   data,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              hold,
  output logic [W-1:0]      out,
  output logic [SELW-1:0]   cur_ch,
  output logic              wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Every select code gets a table entry; codes past CH-1 read as zero.
  localparam int NP = 1 << SELW;

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    ch_data [NP];

  // Unpack the flat channel bus into an index table padded with zeros.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_unpack
      if (gi < CH) begin : g_real
        assign ch_data[gi] = data[gi*W +: W];
      end else begin : g_pad
        assign ch_data[gi] = '0;
      end
    end
  endgenerate

  // Mode FSM and datapath; the action on each edge follows the pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MANUAL;
      ptr    <= '0;
      cnt    <= '0;
      out    <= '0;
      cur_ch <= '0;
      wrap   <= 1'b0;
    end else if (hold) begin
      wrap <= 1'b0;
    end else begin
      state <= mode ? SCAN : MANUAL;
      case (state)
        MANUAL: begin
          out    <= ch_data[sel];
          cur_ch <= sel;
          ptr    <= '0;
          cnt    <= '0;
          wrap   <= 1'b0;
        end
        SCAN: begin
          out    <= ch_data[ptr];
          cur_ch <= ptr;
          if (cnt == CW'(DWELL - 1)) begin
            cnt <= '0;
            if (ptr == SELW'(CH - 1)) begin
              ptr  <= '0;
              wrap <= 1'b1;
            end else begin
              ptr  <= ptr + SELW'(1);
              wrap <= 1'b0;
            end
          end else begin
            cnt  <= cnt + CW'(1);
            wrap <= 1'b0;
          end
        end
        default: begin
          wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_selector.sv
// tb_scan_selector: directed checks of scan_selector with default
// parameters (CH=4, W=2, DWELL=4) and a corner instance (CH=3, W=4, DWELL=1).
module tb_scan_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [1:0] sel;
  logic       mode;
  logic       hold;
  logic [1:0] out;
  logic [1:0] cur_ch;
  logic       wrap;

  logic [11:0] data2;
  logic [1:0]  sel2;
  logic        mode2;
  logic        hold2;
  logic [3:0]  out2;
  logic [1:0]  cur_ch2;
  logic        wrap2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_selector #(.CH(4), .W(2), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .data(data), .sel(sel), .mode(mode), .hold(hold),
    .out(out), .cur_ch(cur_ch), .wrap(wrap)
  );

  scan_selector #(.CH(3), .W(4), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .data(data2), .sel(sel2), .mode(mode2), .hold(hold2),
    .out(out2), .cur_ch(cur_ch2), .wrap(wrap2)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; data = 8'b11_10_01_00; sel = 2'd3; mode = 1'b0; hold = 1'b0;
    data2 = 12'hCA5; sel2 = 2'd0; mode2 = 1'b0; hold2 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out !== 2'b11) begin n_err++; $display("FAIL reset_setup out=%b exp=11", out); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out, cur_ch, wrap} !== 5'b0) begin
      n_err++; $display("FAIL reset_async out=%b cur_ch=%0d wrap=%b exp=0/0/0", out, cur_ch, wrap);
    end
    #1 rst = 1'b0;
    sel = 2'd2;
    tick();
    n_cmp++;
    if (out !== 2'b10 || cur_ch !== 2'd2) begin
      n_err++; $display("FAIL reset_release out=%b cur_ch=%0d exp=10/2", out, cur_ch);
    end
  endtask

  task automatic test_manual_sweep();
    logic [1:0] exp_out [4];
    exp_out[0] = 2'b10; exp_out[1] = 2'b01; exp_out[2] = 2'b11; exp_out[3] = 2'b00;
    mode = 1'b0; data = 8'b00_11_01_10;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      n_cmp++;
      if (out !== exp_out[i] || cur_ch !== 2'(i) || wrap !== 1'b0) begin
        n_err++;
        $display("FAIL manual_sel%0d out=%b cur_ch=%0d wrap=%b exp=%b/%0d/0", i, out, cur_ch, wrap, exp_out[i], i);
      end
    end
  endtask

  task automatic test_scan();
    data = 8'b11_10_01_00; mode = 1'b1; sel = 2'd0;
    tick();  // transition edge, still manual
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_cmp++;
      if (out !== 2'((e - 1) / 4) || cur_ch !== 2'((e - 1) / 4) || wrap !== (e == 16)) begin
        n_err++;
        $display("FAIL scan_edge%0d out=%b cur_ch=%0d wrap=%b exp=%0d/%0d/%0d",
                 e, out, cur_ch, wrap, (e - 1) / 4, (e - 1) / 4, e == 16);
      end
    end
  endtask

  task automatic test_hold();
    // Scan is at channel 0 with a fresh dwell after the wrap.
    for (int e = 0; e < 4; e++) tick();
    for (int e = 0; e < 2; e++) tick();
    n_cmp++;
    if (out !== 2'b01 || cur_ch !== 2'd1) begin
      n_err++; $display("FAIL hold_setup out=%b cur_ch=%0d exp=01/1", out, cur_ch);
    end
    hold = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      n_cmp++;
      if (out !== 2'b01 || cur_ch !== 2'd1 || wrap !== 1'b0) begin
        n_err++; $display("FAIL hold_frozen%0d out=%b cur_ch=%0d wrap=%b exp=01/1/0", e, out, cur_ch, wrap);
      end
    end
    hold = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      n_cmp++;
      if (out !== 2'b01 || cur_ch !== 2'd1) begin
        n_err++; $display("FAIL hold_resume%0d out=%b cur_ch=%0d exp=01/1", e, out, cur_ch);
      end
    end
    tick();
    n_cmp++;
    if (out !== 2'b10 || cur_ch !== 2'd2) begin
      n_err++; $display("FAIL hold_next out=%b cur_ch=%0d exp=10/2", out, cur_ch);
    end
  endtask

  task automatic test_mode_switch();
    // Mid-dwell on channel 2.
    mode = 1'b0; sel = 2'd3;
    tick();
    n_cmp++;
    if (out !== 2'b10 || cur_ch !== 2'd2) begin
      n_err++; $display("FAIL s2m_last out=%b cur_ch=%0d exp=10/2", out, cur_ch);
    end
    tick();
    n_cmp++;
    if (out !== 2'b11 || cur_ch !== 2'd3) begin
      n_err++; $display("FAIL s2m_manual out=%b cur_ch=%0d exp=11/3", out, cur_ch);
    end
    mode = 1'b1;
    tick();
    n_cmp++;
    if (out !== 2'b11 || cur_ch !== 2'd3) begin
      n_err++; $display("FAIL m2s_latency out=%b cur_ch=%0d exp=11/3", out, cur_ch);
    end
    for (int e = 0; e < 4; e++) begin
      if (e == 2) data = 8'b11_10_01_11;  // channel 0 changes mid-dwell
      tick();
      n_cmp++;
      if (out !== (e >= 2 ? 2'b11 : 2'b00) || cur_ch !== 2'd0) begin
        n_err++; $display("FAIL m2s_ch0_%0d out=%b cur_ch=%0d exp=%b/0", e, out, cur_ch, e >= 2 ? 2'b11 : 2'b00);
      end
    end
    tick();
    n_cmp++;
    if (out !== 2'b01 || cur_ch !== 2'd1) begin
      n_err++; $display("FAIL m2s_ch1 out=%b cur_ch=%0d exp=01/1", out, cur_ch);
    end
  endtask

  task automatic test_reset_mid_scan();
    data = 8'b11_10_01_00; sel = 2'd1;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out, cur_ch, wrap} !== 5'b0) begin
      n_err++; $display("FAIL rst_scan_async out=%b cur_ch=%0d wrap=%b exp=0/0/0", out, cur_ch, wrap);
    end
    #1 rst = 1'b0;
    tick();
    n_cmp++;
    if (out !== 2'b01 || cur_ch !== 2'd1) begin
      n_err++; $display("FAIL rst_scan_manual out=%b cur_ch=%0d exp=01/1", out, cur_ch);
    end
    tick();
    n_cmp++;
    if (out !== 2'b00 || cur_ch !== 2'd0) begin
      n_err++; $display("FAIL rst_scan_restart out=%b cur_ch=%0d exp=00/0", out, cur_ch);
    end
  endtask

  task automatic test_corner();
    logic [3:0] exp_val [3];
    exp_val[0] = 4'h5; exp_val[1] = 4'hA; exp_val[2] = 4'hC;
    data2 = 12'hCA5; sel2 = 2'd0; mode2 = 1'b1;
    tick();  // transition edge
    for (int e = 0; e < 7; e++) begin
      tick();
      n_cmp++;
      if (out2 !== exp_val[e % 3] || cur_ch2 !== 2'(e % 3) || wrap2 !== (e % 3 == 2)) begin
        n_err++;
        $display("FAIL corner_scan%0d out=%h cur_ch=%0d wrap=%b exp=%h/%0d/%0d",
                 e, out2, cur_ch2, wrap2, exp_val[e % 3], e % 3, e % 3 == 2);
      end
    end
    mode2 = 1'b0; sel2 = 2'd3;
    tick();
    tick();
    n_cmp++;
    if (out2 !== 4'h0 || cur_ch2 !== 2'd3 || wrap2 !== 1'b0) begin
      n_err++; $display("FAIL corner_sel3 out=%h cur_ch=%0d wrap=%b exp=0/3/0", out2, cur_ch2, wrap2);
    end
    sel2 = 2'd2;
    tick();
    n_cmp++;
    if (out2 !== 4'hC || cur_ch2 !== 2'd2) begin
      n_err++; $display("FAIL corner_sel2 out=%h cur_ch=%0d exp=c/2", out2, cur_ch2);
    end
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_scan();
    test_hold();
    test_mode_switch();
    test_reset_mid_scan();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_selector.md
Name: scan_selector

Overview:
- Parametrised N-channel, W-bit registered selector. Successor to the fixed 4:1 two-bit switch selector.
- Manual mode: an external select picks the channel.
- Auto-scan mode: a dwell counter steps round-robin through all channels and pulses a flag on wrap.
- Sits between the board switch inputs and the LED/display outputs. Also serves as a generic channel scanner for seven-segment and LED multiplexing.

Parameters:
- CH, 4, number of input channels (>=1).
- W, 2, bits per channel.
- SELW, $clog2(CH) (min 1), width of select and channel-index signals.
- DWELL, 4, clock edges each channel is shown in scan mode (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data  input  CH*W  channel inputs; channel i = data[i*W +: W].
- sel  input  SELW  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- hold  input  1  freeze all state and outputs.
- out  output  W  registered selected channel value.
- cur_ch  output  SELW  index of the channel that produced out.
- wrap  output  1  one-cycle pulse when scan wraps CH-1 -> 0.

Behaviour:
- Reset (async, rst=1), immediately and while asserted:
  - out=0, cur_ch=0, wrap=0.
  - state=MANUAL, internal ptr=0, dwell cnt=0.
- All updates occur on the rising clk edge with rst=0.
- hold=1 edge:
  - state, ptr, cnt, out and cur_ch keep their values; wrap<=0.
  - hold has priority over mode changes: no transition happens while held.
- State register:
  - Two states, MANUAL and SCAN.
  - Each non-hold edge: state<=SCAN if mode=1, else MANUAL.
  - The datapath action on that edge follows the current (pre-edge) state, so a mode change takes effect one edge later.
- MANUAL edge:
  - If sel<CH: out<=data[sel], cur_ch<=sel.
  - If sel>=CH (CH not a power of two): out<=0, cur_ch<=sel.
  - ptr<=0, cnt<=0, wrap<=0.
- SCAN edge:
  - Always: out<=data[ptr], cur_ch<=ptr.
  - If cnt==DWELL-1: cnt<=0 and ptr advances.
    - ptr<=ptr+1 normally.
    - ptr<=0 if ptr==CH-1; wrap<=1 on that edge only.
  - Otherwise: cnt<=cnt+1, wrap<=0.
  - Result: each channel appears on out for exactly DWELL consecutive non-hold edges, starting at channel 0 after entry.
- Latency:
  - out reflects data sampled at the previous edge (1 cycle).
  - data changes during a dwell are tracked every edge, not latched once per dwell.
- Boundary cases:
  - DWELL=1: ptr advances every non-hold edge.
  - CH=1: ptr stays 0; wrap pulses every DWELL edges in SCAN.
  - SCAN->MANUAL: ptr/cnt clear on the first MANUAL edge. Re-entering SCAN always restarts at channel 0 with a full dwell.
  - hold mid-dwell: cnt is preserved. After release, the remaining dwell edges complete, so the total is still DWELL.
  - Reset mid-scan: returns asynchronously to the reset values; the first edge after release runs as MANUAL.
- No combinational path from inputs to outputs.
- cnt width: $clog2(DWELL), min 1.

Test Plan:
1. Reset/async:
   - Setup: rst=1 mid-cycle with out=2'b11.
   - Stimulus/response: out, cur_ch and wrap go to 0 before the next edge. After release with mode=0, sel=2, data=8'b11_10_01_00, the next edge gives out=2'b10, cur_ch=2.
2. Manual sweep:
   - Setup: mode=0, data=8'b00_11_01_10.
   - Stimulus: sel=0,1,2,3 on successive edges.
   - Response: out=10,01,11,00 one edge later each; wrap stays 0 throughout.
3. Scan timing:
   - Setup: CH=4, DWELL=4, data=8'b11_10_01_00; assert mode=1.
   - Response, counting after the transition edge:
     - out=00 for 4 edges, then 01, 10, 11 for 4 edges each.
     - wrap=1 on exactly the 16th scan edge; cur_ch matches out.
4. Hold:
   - Setup: scan mode; after 2 edges on channel 1, hold=1 for 5 edges.
   - Response: out=01, cur_ch=1, wrap=0 frozen for all 5 edges. After release, channel 1 persists 2 more edges, then channel 2.
5. Mode switching:
   - Scan->manual: mid-scan on channel 2, set mode=0 with sel=3. out=data[2] for one more edge, then data[3].
   - Manual->scan: mode=1 again. After a one-edge latency the scan restarts at channel 0 with a full DWELL.
6. Corner params:
   - CH=3, DWELL=1, W=4: scan cycles 0,1,2,0 every edge, with wrap on each return to 0.
   - Manual sel=3: out=0, cur_ch=3.
